eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
N-channel GMII transmit arbiter. It is the parametrised successor to the two-protocol (ARP/ICMP) TX switch, for designs carrying additional protocol engines such as UDP.
- Latches per-channel transmit requests and grants one channel at a time.
- Issues a start pulse to the winner and muxes its GMII byte stream onto the shared PHY path.
- Enforces an inter-frame gap between frames and recovers from a hung channel via a watchdog.

Parameters:
NUM_CH, 2, number of protocol channels (2..8)
DATA_W, 8, GMII data width per channel
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
IFG_CYCLES, 12, idle cycles forced between frames; 0 is treated as 1
TIMEOUT_CYCLES, 4096, maximum cycles from start to done; 0 disables the watchdog

Ports:
clk  in  1  GMII TX clock; all logic runs on this single clock
rst_n  in  1  asynchronous active-low reset
ch_req  in  NUM_CH  per-channel transmit request; a one-cycle pulse or a level
ch_start  out  NUM_CH  one-cycle start pulse to the granted channel
ch_done  in  NUM_CH  per-channel frame-complete pulse
ch_tx_en  in  NUM_CH  per-channel GMII tx_en
ch_txd  in  NUM_CH*DATA_W  per-channel GMII data; channel i occupies bits [i*DATA_W +: DATA_W]
gmii_tx_en  out  1  registered shared tx_en
gmii_txd  out  DATA_W  registered shared data
grant  out  NUM_CH  one-hot current owner; all zero when no channel owns the path
busy  out  1  high in every state except IDLE
timeout_err  out  1  one-cycle pulse when the watchdog aborts a frame

Behaviour:
- Reset values: every output is 0, every pending bit is 0, state = IDLE, round-robin pointer = 0, all counters = 0.
- Pending register:
  - pending[i] is set by ch_req[i] and cleared in START for the winner.
  - If set and clear coincide on the same bit, set wins, so a re-request is never lost.
- State machine (IDLE, START, XMIT, GAP):
  - IDLE: if pending != 0, register the winner into grant and go to START. Otherwise stay in IDLE.
  - START: assert ch_start[winner] for exactly one cycle, clear pending[winner], clear the watchdog counter, go to XMIT.
  - XMIT: the winner's ch_tx_en/ch_txd drive the output register. Exit to GAP on ch_done[winner]. Also exit to GAP when the watchdog reaches TIMEOUT_CYCLES-1; in that case pulse timeout_err.
  - GAP: grant = 0 and outputs are idle. Stay for max(IFG_CYCLES,1) cycles, then go to IDLE.
- Arbitration:
  - Fixed mode: the lowest-index pending bit wins.
  - Round-robin mode: the search starts at the pointer and wraps modulo NUM_CH. On grant to channel i, the pointer becomes (i+1) mod NUM_CH.
- Ignored inputs:
  - ch_done from non-granted channels is ignored.
  - ch_tx_en/ch_txd from non-granted channels are ignored.
- Latency: gmii_tx_en/gmii_txd lag ch_tx_en/ch_txd of the winner by 1 cycle.
- Output data rule: gmii_txd = 0 whenever gmii_tx_en = 0.
- Request during own frame: a request from the channel currently in XMIT sets pending again. It is served after GAP, subject to arbitration.
- ch_done in the START cycle is ignored. The frame is defined to begin in XMIT.
- Asynchronous reset mid-frame: returns to IDLE immediately, outputs go to 0, and all pending requests are lost.
- Watchdog: counts in XMIT only and saturates. Its width is clog2(TIMEOUT_CYCLES+1).

Decomposition:
- Package eth_pkg holds:
  - state encoding (IDLE/START/XMIT/GAP)
  - ARB_FIXED/ARB_RR mode constants
  - default IFG constant 12
- One sub-module, eth_rr_pick: a combinational one-hot winner selector. Inputs: pending, pointer, mode. Outputs: one-hot winner and its index.

Test Plan:
1. Single request: ARB_MODE=1, NUM_CH=2; pulse ch_req[1] at t0 -> ch_start[1] at t0+2. Drive 64 bytes 0x00..0x3F with ch_tx_en[1] -> identical bytes appear on gmii_txd 1 cycle later. After ch_done, gmii_tx_en stays 0 for 12 cycles, then busy=0.
2. Simultaneous requests, round-robin: NUM_CH=3, pulse ch_req=3'b111 in the same cycle -> grants follow the order 0, 1, 2. Repeat with pointer=1 -> order is 1, 2, 0.
3. Simultaneous requests, fixed priority: ARB_MODE=0, ch_req[2] held as a level, ch_req[0] pulsed during channel 2's frame -> channel 0 is granted next. A repeat of ch_req[2] raised during the frame is still served afterwards (not lost).
4. Watchdog: TIMEOUT_CYCLES=100, channel 0 never asserts ch_done -> timeout_err pulses exactly at cycle 100 of XMIT. The state passes through GAP, and pending channel 1 is granted afterwards.
5. Noise isolation: channel 1 drives ch_tx_en=1 with ch_txd=0xAA and pulses ch_done while channel 0 is granted -> gmii_txd carries only channel 0 data and channel 0's frame is not terminated.
6. Reset mid-frame: deassert rst_n during XMIT -> all outputs are 0 in the same cycle. After release, the block sits in IDLE with pending = 0.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the GMII transmit arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eth_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XMIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Arbitration modes, as seen on the selector's mode input
    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // Default inter-frame gap in GMII clock cycles
    localparam int IFG_DEFAULT = 12;

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational winner selector: fixed-priority or round-robin from a pointer.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the owner samples the result only when it can accept a grant.
//
// Ports:
//   i_pending  pending request bits
//   i_ptr      round-robin search start index
//   i_mode     ARB_FIXED (lowest index wins) or ARB_RR (search from i_ptr, wrapping)
//   o_win_oh   one-hot winner, zero when nothing is pending
//   o_win_idx  index of the winner, zero when nothing is pending
module eth_rr_pick
    import eth_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] i_pending,
    input  logic [IDX_W-1:0]  i_ptr,
    input  logic              i_mode,
    output logic [NUM_CH-1:0] o_win_oh,
    output logic [IDX_W-1:0]  o_win_idx
);

    logic w_found;
    int   w_cand;

    // Walk candidates in search order; the first pending one wins.
    always_comb begin
        o_win_oh  = '0;
        o_win_idx = '0;
        w_found   = 1'b0;
        w_cand    = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_cand = (i_mode == ARB_RR) ? int'(i_ptr) + k : k;
            if (w_cand >= NUM_CH) begin
                w_cand = w_cand - NUM_CH;
            end
            if (!w_found && i_pending[w_cand]) begin
                w_found          = 1'b1;
                o_win_oh[w_cand] = 1'b1;
                o_win_idx        = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// N-channel GMII TX arbiter: latches requests, grants one channel, muxes its byte stream.
// Latency: start pulse 2 cycles after a request into an idle block; gmii_* lag the winner by 1 cycle.
// Backpressure: requests are held in a pending register until served; no flow control on the data path.
//
// Ports:
//   clk, rst_n      GMII TX clock, asynchronous active-low reset
//   ch_req          per-channel request (pulse or level)
//   ch_start        one-cycle start pulse to the granted channel
//   ch_done         per-channel frame-complete pulse (only the owner's is observed)
//   ch_tx_en/ch_txd per-channel GMII stream, channel i at ch_txd[i*DATA_W +: DATA_W]
//   gmii_tx_en/txd  registered shared stream; txd forced to 0 when tx_en is 0
//   grant           one-hot owner, zero outside START/XMIT
//   busy            high whenever the state is not IDLE
//   timeout_err     one-cycle pulse when the watchdog aborts a frame
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int DATA_W         = 8,
    parameter int ARB_MODE       = 1,
    parameter int IFG_CYCLES     = IFG_DEFAULT,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_req,
    output logic [NUM_CH-1:0]        ch_start,
    input  logic [NUM_CH-1:0]        ch_done,
    input  logic [NUM_CH-1:0]        ch_tx_en,
    input  logic [NUM_CH*DATA_W-1:0] ch_txd,
    output logic                     gmii_tx_en,
    output logic [DATA_W-1:0]        gmii_txd,
    output logic [NUM_CH-1:0]        grant,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int   IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int   IFG_EFF  = (IFG_CYCLES < 1) ? 1 : IFG_CYCLES;
    localparam int   GAP_W    = $clog2(IFG_EFF + 1);
    localparam int   WD_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int   WD_LIM   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic MODE_BIT = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

    state_t              r_state;
    logic [NUM_CH-1:0]   r_pending;
    logic [IDX_W-1:0]    r_ptr;
    logic [NUM_CH-1:0]   r_grant;
    logic [IDX_W-1:0]    r_idx;
    logic [NUM_CH-1:0]   r_start;
    logic                r_tx_en;
    logic [DATA_W-1:0]   r_txd;
    logic                r_timeout;
    logic [WD_W-1:0]     r_wd;
    logic [GAP_W-1:0]    r_gap;

    logic [NUM_CH-1:0]   w_win_oh;
    logic [IDX_W-1:0]    w_win_idx;
    logic [IDX_W-1:0]    w_ptr_next;
    logic [NUM_CH-1:0]   w_pend_clr;
    logic                w_sel_en;
    logic [DATA_W-1:0]   w_sel_txd;
    logic                w_sel_done;
    logic                w_wd_hit;

    eth_rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .i_mode    (MODE_BIT),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx)
    );

    // Owner's view of the per-channel inputs; everything else is ignored.
    assign w_sel_en   = ch_tx_en[r_idx];
    assign w_sel_txd  = ch_txd[r_idx*DATA_W +: DATA_W];
    assign w_sel_done = ch_done[r_idx];

    assign w_ptr_next = (w_win_idx == IDX_W'(NUM_CH - 1)) ? '0 : w_win_idx + IDX_W'(1);
    assign w_wd_hit   = (TIMEOUT_CYCLES != 0) && (r_wd == WD_W'(WD_LIM));

    // The owner's bit is dropped in START; a request in that same cycle re-sets it.
    assign w_pend_clr = (r_state == ST_START) ? r_grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_pend_clr) | ch_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_idx     <= '0;
            r_start   <= '0;
            r_timeout <= 1'b0;
            r_wd      <= '0;
            r_gap     <= '0;
        end else begin
            r_start   <= '0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|r_pending) begin
                        r_grant <= w_win_oh;
                        r_idx   <= w_win_idx;
                        r_start <= w_win_oh;
                        if (MODE_BIT == ARB_RR) begin
                            r_ptr <= w_ptr_next;
                        end
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_wd    <= '0;
                    r_state <= ST_XMIT;
                end
                ST_XMIT: begin
                    if (w_sel_done) begin
                        r_grant <= '0;
                        r_gap   <= '0;
                        r_state <= ST_GAP;
                    end else if (w_wd_hit) begin
                        r_grant   <= '0;
                        r_gap     <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= ST_GAP;
                    end else if (r_wd != {WD_W{1'b1}}) begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_W'(IFG_EFF - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output stage: only the owner's stream in XMIT passes; data is zeroed when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_en <= 1'b0;
            r_txd   <= '0;
        end else begin
            r_tx_en <= (r_state == ST_XMIT) && w_sel_en;
            r_txd   <= ((r_state == ST_XMIT) && w_sel_en) ? w_sel_txd : '0;
        end
    end

    assign ch_start    = r_start;
    assign grant       = r_grant;
    assign busy        = (r_state != ST_IDLE);
    assign timeout_err = r_timeout;
    assign gmii_tx_en  = r_tx_en;
    assign gmii_txd    = r_txd;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for eth_tx_arbiter: a round-robin and a fixed-priority instance (3 channels each),
// randomized frames with noise on idle channels, scoreboarded data and model-predicted grants.
// Latency/backpressure: n/a (testbench).
module tb_eth_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0]  req  [2];
    logic [2:0]  done [2];
    logic [2:0]  txen [2];
    logic [23:0] txd  [2];
    logic [2:0]  lvl  [2];
    logic [2:0]  start_o [2];
    logic [2:0]  grant_o [2];
    logic        busy_o  [2];
    logic        terr_o  [2];
    logic        gen_o   [2];
    logic [7:0]  gtxd_o  [2];
    logic [2:0]  rs      [2];

    // Reference model state
    logic [2:0]  pend [2];
    int          ptr  [2];
    logic [7:0]  dq0 [$];
    logic [7:0]  dq1 [$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    eth_tx_arbiter #(.NUM_CH(3), .DATA_W(8), .ARB_MODE(1), .IFG_CYCLES(12), .TIMEOUT_CYCLES(100)) u_rr (
        .clk(clk), .rst_n(rst_n), .ch_req(req[0]), .ch_start(start_o[0]), .ch_done(done[0]),
        .ch_tx_en(txen[0]), .ch_txd(txd[0]), .gmii_tx_en(gen_o[0]), .gmii_txd(gtxd_o[0]),
        .grant(grant_o[0]), .busy(busy_o[0]), .timeout_err(terr_o[0]));

    eth_tx_arbiter #(.NUM_CH(3), .DATA_W(8), .ARB_MODE(0), .IFG_CYCLES(12), .TIMEOUT_CYCLES(100)) u_fx (
        .clk(clk), .rst_n(rst_n), .ch_req(req[1]), .ch_start(start_o[1]), .ch_done(done[1]),
        .ch_tx_en(txen[1]), .ch_txd(txd[1]), .gmii_tx_en(gen_o[1]), .gmii_txd(gtxd_o[1]),
        .grant(grant_o[1]), .busy(busy_o[1]), .timeout_err(terr_o[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which pending channel the rules say wins next.
    function automatic logic [2:0] model_pick(input logic [2:0] p, input int pt, input bit rr);
        int c;
        for (int k = 0; k < 3; k++) begin
            c = ((rr ? pt : 0) + k) % 3;
            if (p[c]) return 3'b001 << c;
        end
        return 3'b000;
    endfunction

    always @(posedge clk) begin
        rs[0] <= req[0];
        rs[1] <= req[1];
    end

    // Monitor: grant prediction and data scoreboard for both instances.
    initial begin : monitor
        logic [2:0] e;
        logic [7:0] b;
        pend[0] = 3'b0; pend[1] = 3'b0; ptr[0] = 0; ptr[1] = 0;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (!rst_n) begin
                    pend[m] = 3'b0;
                    ptr[m]  = 0;
                end else begin
                    pend[m] = pend[m] | rs[m];
                    if (start_o[m] != 3'b0) begin
                        e = model_pick(pend[m], ptr[m], m == 0);
                        chk("grant_order", {29'd0, start_o[m]}, {29'd0, e});
                        chk("grant_reg", {29'd0, grant_o[m]}, {29'd0, e});
                        pend[m] = pend[m] & ~e;
                        if (m == 0) begin
                            for (int c = 0; c < 3; c++) if (e[c]) ptr[0] = (c + 1) % 3;
                        end
                    end
                    if (gen_o[m]) begin
                        if ((m == 0 && dq0.size() == 0) || (m == 1 && dq1.size() == 0)) begin
                            checks++; failures++;
                            $display("FAIL unexpected_byte inst=%0d actual=%0h required=none", m, gtxd_o[m]);
                        end else begin
                            b = (m == 0) ? dq0.pop_front() : dq1.pop_front();
                            chk("gmii_txd", {24'd0, gtxd_o[m]}, {24'd0, b});
                        end
                    end else begin
                        chk("txd_idle_zero", {24'd0, gtxd_o[m]}, 32'd0);
                    end
                end
            end
        end
    end

    task automatic wait_start(input int m, input int bound, output logic [2:0] oh, output int cyc);
        cyc = 0;
        oh  = 3'b0;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (start_o[m] != 3'b0) begin
                oh = start_o[m];
                return;
            end
        end
        checks++; failures++;
        $display("FAIL start_wait inst=%0d actual=no_start required=start_within_%0d", m, bound);
    endtask

    // Serve one frame from the START cycle onward, then check the gap (or the watchdog).
    task automatic serve(input int m, input logic [2:0] oh, input int len, input bit hang,
                         input bit inc, input logic [2:0] pulse, input bit drop_lvl);
        logic [7:0] d;
        bit         en;
        int         cnt;
        done[m] = oh & {3{$urandom_range(0, 1) == 1}};  // owner's done in START must be ignored
        for (int b = 0; b < len; b++) begin
            @(negedge clk);
            en = inc || ($urandom_range(0, 7) != 0);
            d  = inc ? b[7:0] : 8'($urandom);
            txen[m] = (en ? oh : 3'b0) | (3'($urandom) & ~oh);
            txd[m]  = 24'hAAAAAA;
            for (int c = 0; c < 3; c++) if (oh[c]) txd[m][c*8 +: 8] = d;
            done[m] = 3'($urandom) & ~oh;
            if (b == 2 && drop_lvl) lvl[m] = 3'b0;
            req[m] = lvl[m] | ((b == 1) ? pulse : 3'b0);
            if (en) begin
                if (m == 0) dq0.push_back(d); else dq1.push_back(d);
            end
        end
        @(negedge clk);
        txen[m] = 3'b0; txd[m] = 24'h0; req[m] = lvl[m];
        if (!hang) begin
            done[m] = oh;
            @(negedge clk);
            done[m] = 3'b0;
            chk("gap_grant", {29'd0, grant_o[m]}, 32'd0);
            cnt = 0;
        end else begin
            done[m] = 3'b0;
            cnt = len + 1;
            while (!terr_o[m] && cnt < 300) begin
                @(negedge clk);
                cnt++;
            end
            chk("timeout_at", cnt, 101);
            chk("timeout_grant", {29'd0, grant_o[m]}, 32'd0);
            @(negedge clk);
            chk("timeout_pulse", {31'd0, terr_o[m]}, 32'd0);
            cnt = 1;
        end
        while (busy_o[m] && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("gap_len", cnt, 12);
    endtask

    task automatic round(input int m, input logic [2:0] mask, input bit level, input bit hang_first, input bit inc);
        logic [2:0] oh, pm;
        int         cyc;
        bit         drop;
        @(negedge clk);
        if (level) lvl[m] = mask;
        req[m] = mask;
        @(negedge clk);
        req[m] = lvl[m];
        for (int nf = 0; nf < 12; nf++) begin
            wait_start(m, 20, oh, cyc);
            if (nf == 0) chk("start_latency", cyc + 1, 2);
            if (oh == 3'b0) break;
            pm = 3'b0;
            drop = 1'b0;
            if (level) begin
                if (nf == 0) pm = 3'b001;
                if (nf == 1) drop = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
                pm = 3'b001 << $urandom_range(0, 2);
            end
            serve(m, oh, inc && nf == 0 ? 64 : $urandom_range(3, 40), hang_first && nf == 0,
                  inc && nf == 0, pm, drop);
            if (pend[m] == 3'b0) break;
        end
        chk("round_idle", {31'd0, busy_o[m]}, 32'd0);
    endtask

    task automatic chk_zero(input int m, input string tag);
        chk({tag, "_busy"},  {31'd0, busy_o[m]},  32'd0);
        chk({tag, "_grant"}, {29'd0, grant_o[m]}, 32'd0);
        chk({tag, "_start"}, {29'd0, start_o[m]}, 32'd0);
        chk({tag, "_txen"},  {31'd0, gen_o[m]},   32'd0);
        chk({tag, "_txd"},   {24'd0, gtxd_o[m]},  32'd0);
        chk({tag, "_terr"},  {31'd0, terr_o[m]},  32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [2:0] oh;
        int         cyc;
        for (int m = 0; m < 2; m++) begin
            req[m] = 3'b0; done[m] = 3'b0; txen[m] = 3'b0; txd[m] = 24'h0; lvl[m] = 3'b0;
        end
        repeat (3) @(negedge clk);
        chk_zero(0, "rst_rr");
        chk_zero(1, "rst_fx");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Round-robin: all-at-once from pointer 0, then move pointer to 1, then all-at-once again
        round(0, 3'b111, 1'b0, 1'b0, 1'b0);
        round(0, 3'b001, 1'b0, 1'b0, 1'b0);
        round(0, 3'b111, 1'b0, 1'b0, 1'b0);
        round(0, 3'b010, 1'b0, 1'b0, 1'b1);   // 64 incrementing bytes
        round(0, 3'b011, 1'b0, 1'b1, 1'b0);   // first owner hangs
        for (int r = 0; r < 10; r++) round(0, 3'($urandom_range(1, 7)), 1'b0, 1'b0, 1'b0);

        // Fixed priority: channel 2 held as a level, channel 0 pulsed during its frame
        round(1, 3'b100, 1'b1, 1'b0, 1'b0);
        round(1, 3'b110, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 6; r++) round(1, 3'($urandom_range(1, 7)), 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a frame with another request pending
        @(negedge clk); req[0] = 3'b001;
        @(negedge clk); req[0] = 3'b000;
        wait_start(0, 20, oh, cyc);
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            txen[0] = oh;
            txd[0]  = {3{8'(b + 8'h50)}};
            req[0]  = (b == 1) ? 3'b010 : 3'b000;
            dq0.push_back(8'(b + 8'h50));
        end
        @(negedge clk);
        txen[0] = 3'b0; txd[0] = 24'h0;
        #2 rst_n = 1'b0;
        #1 chk_zero(0, "midrst");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk_zero(0, "post_rst");

        chk("dq0_empty", dq0.size(), 0);
        chk("dq1_empty", dq1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
